// File: rtl/vga_params_pkg.sv
// Screen geometry, pixel-entry layout and address helpers shared by the screen
// generators and the pixel sink.
package vga_params;

    localparam int WIDTH    = 320;
    localparam int HEIGHT   = 240;
    localparam int COLOUR_W = 3;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;
    localparam int IN_X_W   = 9;
    localparam int IN_Y_W   = 9;
    localparam int ADDR_W   = 17;
    localparam int DEPTH    = 8;
    localparam int CLIP_W   = 16;

    typedef struct packed {
        logic                clip;
        logic                last;
        logic [COLOUR_W-1:0] colour;
        logic [IN_Y_W-1:0]   y;
        logic [IN_X_W-1:0]   x;
    } pix_entry_t;

    localparam int ENTRY_W = $bits(pix_entry_t);

    function automatic logic is_clipped(input logic [IN_X_W-1:0] x, input logic [IN_Y_W-1:0] y);
        return (x >= IN_X_W'(WIDTH)) || (y >= IN_Y_W'(HEIGHT));
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [IN_X_W-1:0] x, input logic [IN_Y_W-1:0] y);
        return (ADDR_W'(y) * ADDR_W'(WIDTH)) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; the head entry is visible
// combinationally on o_data whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH_BITS = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH_BITS-1:0]    i_data,
    input  logic                     i_pop,
    output logic [WIDTH_BITS-1:0]    o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [WIDTH_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [COUNT_W-1:0]    r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == COUNT_W'(DEPTH));
    assign o_empty   = (r_count == COUNT_W'(0));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage array; flushing is done through the pointers, so no reset here.
    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= COUNT_W'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_pixel_sink.sv
// Pixel-stream sink: buffers (x, y, colour, last), drops off-screen pixels and
// presents on-screen ones to the VGA adapter with a precomputed frame-buffer address.
module vga_pixel_sink
    import vga_params::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [IN_X_W-1:0]   i_in_x,
    input  logic [IN_Y_W-1:0]   i_in_y,
    input  logic [COLOUR_W-1:0] i_in_colour,
    input  logic                i_in_last,
    input  logic                i_out_ready,
    output logic                o_vga_plot,
    output logic [X_W-1:0]      o_vga_x,
    output logic [Y_W-1:0]      o_vga_y,
    output logic [COLOUR_W-1:0] o_vga_colour,
    output logic [ADDR_W-1:0]   o_fb_addr,
    output logic                o_done,
    output logic [CLIP_W-1:0]   o_clip_count
);

    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic                 r_rdy_en;
    logic                 r_out_valid;
    pix_entry_t           r_out;
    logic [ADDR_W-1:0]    r_fb_addr;
    logic [CLIP_W-1:0]    r_clip_count;

    pix_entry_t           w_in_entry;
    pix_entry_t           w_head;
    logic [ENTRY_W-1:0]   w_head_bits;
    logic                 w_full;
    logic                 w_empty;
    logic [COUNT_W-1:0]   w_count;
    logic                 w_accept;
    logic                 w_retire;
    logic                 w_load;

    // Readiness comes from registered occupancy only, so a pop in the same
    // cycle never opens a slot combinationally.
    assign o_in_ready = r_rdy_en && (w_count != COUNT_W'(DEPTH));
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_retire   = r_out_valid && (r_out.clip || i_out_ready);
    assign w_load     = !w_empty && (!r_out_valid || w_retire);
    assign w_head     = w_head_bits;

    // Build the entry stored for an incoming pixel.
    always_comb begin
        w_in_entry        = '0;
        w_in_entry.clip   = is_clipped(i_in_x, i_in_y);
        w_in_entry.last   = i_in_last;
        w_in_entry.colour = i_in_colour;
        w_in_entry.y      = i_in_y;
        w_in_entry.x      = i_in_x;
    end

    sync_fifo #(
        .WIDTH_BITS (ENTRY_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_accept && !w_full),
        .i_data  (w_in_entry),
        .i_pop   (w_load),
        .o_data  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Input side comes up one edge after reset is released.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Output register: refills from the FIFO head when empty or retiring.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_fb_addr   <= ADDR_W'(0);
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out       <= w_head;
            r_fb_addr   <= pix_addr(w_head.x, w_head.y);
        end else if (w_retire) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Saturating count of accepted off-screen pixels.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_clip_count <= CLIP_W'(0);
        end else if (w_accept && w_in_entry.clip && (r_clip_count != {CLIP_W{1'b1}})) begin
            r_clip_count <= r_clip_count + CLIP_W'(1);
        end else begin
            r_clip_count <= r_clip_count;
        end
    end

    assign o_vga_plot   = r_out_valid && !r_out.clip;
    assign o_vga_x      = r_out.x;
    assign o_vga_y      = r_out.y[Y_W-1:0];
    assign o_vga_colour = r_out.colour;
    assign o_fb_addr    = r_fb_addr;
    assign o_done       = w_retire && r_out.last;
    assign o_clip_count = r_clip_count;

endmodule
